discharge_pulse_fsm: RTL and testbench

- Pulse-generator state machine that sits directly downstream of the breakdown detector.
- Drives the 8-bit one-hot current_state bus that the detector monitors, and consumes the detector's is_breakdown flag.
- Sequences each EDM discharge cycle: gap voltage on, wait for breakdown, timed Ton discharge, timed Toff deionisation.
- Adds open-gap timeout and short-circuit cut-off, and keeps statistics counters.

---
 rtl/discharge_pulse_fsm.sv | 158 +++++++++++++++
 tb/tb_discharge_pulse_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/discharge_pulse_fsm.sv
// EDM pulse generator: sequences gap-on / breakdown wait / Ton discharge / Toff deionisation,
// with open-gap timeout, short-circuit cut-off and saturating statistics counters.
module discharge_pulse_fsm #(
  parameter logic        [15:0] WAIT_TIMEOUT         = 16'd5000,
  parameter logic signed [15:0] SHORT_THRESHOLD_CUR  = 16'sd60,
  parameter logic        [15:0] SHORT_THRESHOLD_TIME = 16'd20,
  parameter logic        [15:0] SHORT_RECOVER_CYCLES = 16'd2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               is_breakdown,
  input  logic signed [15:0] sample_current,
  input  logic        [15:0] ton_cycles,
  input  logic        [15:0] toff_cycles,
  output logic        [7:0]  current_state,
  output logic               mosfet_on,
  output logic               discharge_done,
  output logic               short_flag,
  output logic        [31:0] pulse_count,
  output logic        [15:0] open_count,
  output logic        [15:0] short_count
);

  typedef enum logic [7:0] {
    S_WAIT_BREAKDOWN = 8'b0000_0001,
    S_DISCHARGE      = 8'b0000_0010,
    S_DEION          = 8'b0000_0100,
    S_SHORT          = 8'b0000_1000,
    S_IDLE           = 8'b0001_0000
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] short_cnt_q, short_cnt_d;
  logic [15:0] ton_q, toff_q;
  logic [15:0] ton_eff, toff_eff;
  logic        latch_en, done_d, pulse_inc, open_inc, short_inc;
  logic        mosfet_on_q, discharge_done_q, short_flag_q;
  logic [31:0] pulse_count_q;
  logic [15:0] open_count_q, short_count_q;

  // A zero on-/off-time would never match the terminal count, so it is clamped to one cycle.
  assign ton_eff  = (ton_cycles  == 16'd0) ? 16'd1 : ton_cycles;
  assign toff_eff = (toff_cycles == 16'd0) ? 16'd1 : toff_cycles;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    timer_d     = timer_q + 16'd1;
    short_cnt_d = 16'd0;
    latch_en    = 1'b0;
    done_d      = 1'b0;
    pulse_inc   = 1'b0;
    open_inc    = 1'b0;
    short_inc   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d = 16'd0;
        if (enable) begin
          state_d  = S_WAIT_BREAKDOWN;
          latch_en = 1'b1;
        end
      end
      S_WAIT_BREAKDOWN: begin
        if (is_breakdown) begin
          state_d = S_DISCHARGE;
          timer_d = 16'd0;
        end else if (timer_q == WAIT_TIMEOUT - 16'd1) begin
          state_d  = S_DEION;
          timer_d  = 16'd0;
          open_inc = 1'b1;
        end else if (!enable) begin
          state_d = S_IDLE;
          timer_d = 16'd0;
        end
      end
      S_DISCHARGE: begin
        short_cnt_d = (sample_current >= SHORT_THRESHOLD_CUR) ? short_cnt_q + 16'd1 : 16'd0;
        // Short detection wins over a Ton expiry landing on the same cycle.
        if (short_cnt_d == SHORT_THRESHOLD_TIME) begin
          state_d     = S_SHORT;
          timer_d     = 16'd0;
          short_cnt_d = 16'd0;
          short_inc   = 1'b1;
        end else if (timer_q == ton_q - 16'd1) begin
          state_d     = S_DEION;
          timer_d     = 16'd0;
          short_cnt_d = 16'd0;
          pulse_inc   = 1'b1;
          done_d      = 1'b1;
        end
      end
      S_DEION: begin
        if (timer_q == toff_q - 16'd1) begin
          timer_d = 16'd0;
          if (enable) begin
            state_d  = S_WAIT_BREAKDOWN;
            latch_en = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_SHORT: begin
        if (timer_q == SHORT_RECOVER_CYCLES - 16'd1) begin
          state_d = S_DEION;
          timer_d = 16'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = 16'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      timer_q          <= 16'd0;
      short_cnt_q      <= 16'd0;
      ton_q            <= 16'd0;
      toff_q           <= 16'd0;
      mosfet_on_q      <= 1'b0;
      discharge_done_q <= 1'b0;
      short_flag_q     <= 1'b0;
      pulse_count_q    <= 32'd0;
      open_count_q     <= 16'd0;
      short_count_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      short_cnt_q <= short_cnt_d;
      if (latch_en) begin
        ton_q  <= ton_eff;
        toff_q <= toff_eff;
      end
      // Outputs decode the next state so they line up with current_state.
      mosfet_on_q      <= (state_d == S_WAIT_BREAKDOWN) || (state_d == S_DISCHARGE);
      short_flag_q     <= (state_d == S_SHORT);
      discharge_done_q <= done_d;
      if (pulse_inc && (pulse_count_q != '1)) pulse_count_q <= pulse_count_q + 32'd1;
      if (open_inc  && (open_count_q  != '1)) open_count_q  <= open_count_q  + 16'd1;
      if (short_inc && (short_count_q != '1)) short_count_q <= short_count_q + 16'd1;
    end
  end

  assign current_state  = state_q;
  assign mosfet_on      = mosfet_on_q;
  assign discharge_done = discharge_done_q;
  assign short_flag     = short_flag_q;
  assign pulse_count    = pulse_count_q;
  assign open_count     = open_count_q;
  assign short_count    = short_count_q;

endmodule

// File: tb/tb_discharge_pulse_fsm.sv
// Directed bench for discharge_pulse_fsm: normal pulse, open timeout, short, glitch,
// enable drop, zero Ton, breakdown/timeout race and asynchronous reset.
module tb_discharge_pulse_fsm;

  localparam logic [7:0] ST_WAIT  = 8'h01;
  localparam logic [7:0] ST_DIS   = 8'h02;
  localparam logic [7:0] ST_DEION = 8'h04;
  localparam logic [7:0] ST_SHORT = 8'h08;
  localparam logic [7:0] ST_IDLE  = 8'h10;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               is_breakdown;
  logic signed [15:0] sample_current;
  logic        [15:0] ton_cycles;
  logic        [15:0] toff_cycles;
  logic        [7:0]  current_state;
  logic               mosfet_on;
  logic               discharge_done;
  logic               short_flag;
  logic        [31:0] pulse_count;
  logic        [15:0] open_count;
  logic        [15:0] short_count;

  int total = 0;
  int bad   = 0;
  int n;

  discharge_pulse_fsm #(
    .WAIT_TIMEOUT(16'd200)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .is_breakdown  (is_breakdown),
    .sample_current(sample_current),
    .ton_cycles    (ton_cycles),
    .toff_cycles   (toff_cycles),
    .current_state (current_state),
    .mosfet_on     (mosfet_on),
    .discharge_done(discharge_done),
    .short_flag    (short_flag),
    .pulse_count   (pulse_count),
    .open_count    (open_count),
    .short_count   (short_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Counts consecutive cycles spent in st starting from the current sample point.
  task automatic count_state(input logic [7:0] st, input int bound, output int cnt);
    cnt = 0;
    while ((current_state === st) && (cnt < bound)) begin
      cnt++;
      step(1);
    end
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    is_breakdown   = 1'b0;
    sample_current = 16'sd0;
    ton_cycles     = 16'd50;
    toff_cycles    = 16'd100;
    step(3);
    check("rst_state", current_state, ST_IDLE);
    check("rst_mosfet", mosfet_on, 0);
    check("rst_pulse_cnt", pulse_count, 0);
    check("rst_open_cnt", open_count, 0);
    check("rst_short_cnt", short_count, 0);

    // Normal pulse: 30 WAIT cycles, 50 DISCHARGE, 100 DEION.
    rst    = 1'b0;
    enable = 1'b1;
    step(1);
    check("wait_entry", current_state, ST_WAIT);
    check("wait_mosfet", mosfet_on, 1);
    step(29);
    check("wait_hold_29", current_state, ST_WAIT);
    is_breakdown = 1'b1;
    step(1);
    check("dis_entry", current_state, ST_DIS);
    check("dis_mosfet", mosfet_on, 1);
    step(1);
    is_breakdown = 1'b0;
    count_state(ST_DIS, 200, n);
    check("dis_len_normal", n + 1, 50);
    check("deion_entry", current_state, ST_DEION);
    check("deion_mosfet", mosfet_on, 0);
    check("done_strobe", discharge_done, 1);
    check("pulse_cnt_1", pulse_count, 1);
    step(1);
    check("done_one_cycle", discharge_done, 0);
    count_state(ST_DEION, 300, n);
    check("deion_len_normal", n + 1, 100);
    check("back_to_wait", current_state, ST_WAIT);

    // Open timeout: WAIT lasts 200 cycles, then DEION without a strobe.
    count_state(ST_WAIT, 300, n);
    check("wait_timeout_len", n, 200);
    check("timeout_deion", current_state, ST_DEION);
    check("open_cnt_1", open_count, 1);
    check("open_no_pulse", pulse_count, 1);
    check("open_no_done", discharge_done, 0);
    ton_cycles = 16'd100;
    count_state(ST_DEION, 300, n);
    check("deion_len_open", n, 100);

    // Short circuit: current above threshold from DISCHARGE cycle 5, cut after 20 cycles.
    check("short_wait", current_state, ST_WAIT);
    is_breakdown = 1'b1;
    step(1);
    is_breakdown = 1'b0;
    check("short_dis_entry", current_state, ST_DIS);
    step(5);
    sample_current = 16'sd80;
    count_state(ST_DIS, 200, n);
    check("short_dis_len", n, 20);
    check("short_entry", current_state, ST_SHORT);
    check("short_flag_on", short_flag, 1);
    check("short_mosfet_off", mosfet_on, 0);
    check("short_cnt_1", short_count, 1);
    sample_current = 16'sd0;
    ton_cycles     = 16'd50;
    is_breakdown   = 1'b1;
    count_state(ST_SHORT, 2100, n);
    is_breakdown = 1'b0;
    check("short_len", n, 2000);
    check("short_to_deion", current_state, ST_DEION);
    check("short_flag_off", short_flag, 0);
    check("short_no_done", discharge_done, 0);
    check("short_no_pulse", pulse_count, 1);
    count_state(ST_DEION, 300, n);
    check("deion_len_short", n, 100);

    // Short glitch: 19 cycles above threshold do not trip; mid-cycle ton change ignored.
    is_breakdown = 1'b1;
    step(1);
    is_breakdown   = 1'b0;
    sample_current = 16'sd80;
    ton_cycles     = 16'd3;
    step(19);
    sample_current = 16'sd0;
    count_state(ST_DIS, 200, n);
    check("glitch_dis_len", n + 19, 50);
    check("glitch_deion", current_state, ST_DEION);
    check("glitch_done", discharge_done, 1);
    check("glitch_pulse_cnt", pulse_count, 2);
    check("glitch_short_cnt", short_count, 1);
    ton_cycles = 16'd50;
    count_state(ST_DEION, 300, n);
    check("deion_len_glitch", n, 100);

    // Enable drop mid-DISCHARGE: discharge and DEION finish, then IDLE.
    is_breakdown = 1'b1;
    step(1);
    is_breakdown = 1'b0;
    step(10);
    enable = 1'b0;
    count_state(ST_DIS, 200, n);
    check("endrop_dis_len", n + 10, 50);
    check("endrop_done", discharge_done, 1);
    check("endrop_pulse_cnt", pulse_count, 3);
    count_state(ST_DEION, 300, n);
    check("endrop_deion_len", n, 100);
    check("endrop_idle", current_state, ST_IDLE);
    check("endrop_idle_mosfet", mosfet_on, 0);
    step(3);
    check("idle_stays", current_state, ST_IDLE);

    // Enable drop in WAIT: IDLE on the next cycle.
    enable = 1'b1;
    step(6);
    check("wait_before_drop", current_state, ST_WAIT);
    enable = 1'b0;
    step(1);
    check("wait_drop_idle", current_state, ST_IDLE);
    check("wait_drop_open_cnt", open_count, 1);

    // Ton = 0 behaves as a 1-cycle discharge.
    ton_cycles = 16'd0;
    enable     = 1'b1;
    step(1);
    is_breakdown = 1'b1;
    step(1);
    is_breakdown = 1'b0;
    count_state(ST_DIS, 200, n);
    check("ton0_dis_len", n, 1);
    check("ton0_done", discharge_done, 1);
    check("ton0_pulse_cnt", pulse_count, 4);
    ton_cycles = 16'd50;
    count_state(ST_DEION, 300, n);
    check("ton0_deion_len", n, 100);

    // Breakdown on the timeout cycle: DISCHARGE wins.
    check("race_wait", current_state, ST_WAIT);
    step(199);
    check("race_wait_199", current_state, ST_WAIT);
    is_breakdown = 1'b1;
    step(1);
    is_breakdown = 1'b0;
    check("race_dis", current_state, ST_DIS);
    check("race_open_cnt", open_count, 1);

    // Asynchronous reset mid-DISCHARGE.
    step(10);
    check("pre_rst_dis", current_state, ST_DIS);
    rst = 1'b1;
    #1;
    check("arst_state", current_state, ST_IDLE);
    check("arst_mosfet", mosfet_on, 0);
    check("arst_pulse_cnt", pulse_count, 0);
    check("arst_open_cnt", open_count, 0);
    check("arst_short_cnt", short_count, 0);
    step(2);
    rst = 1'b0;
    step(1);
    check("post_rst_wait", current_state, ST_WAIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
